// File: rtl/posi_mode_decision.sv
// posi_mode_decision
// Sweeps the intra candidate modes of one PU, adds the SAD of each mode to the
// bitrate returned by the rate estimator, and keeps the cheapest mode.
// A one-cycle cost_done_o pulse presents the winner on mode_o. The rate
// estimator stores that mode as the neighbour mode for later PUs.
module posi_mode_decision #(
    parameter int SAD_WIDTH  = 20,
    parameter int MODE_NUM   = 35,
    parameter int COST_WIDTH = SAD_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            size_i,
    input  logic [7:0]            position_i,
    input  logic                  sad_valid_i,
    input  logic [SAD_WIDTH-1:0]  sad_i,
    input  logic [12:0]           bitrate_i,
    output logic                  busy_o,
    output logic [5:0]            mode_o,
    output logic [1:0]            size_o,
    output logic [7:0]            position_o,
    output logic                  cost_done_o,
    output logic [5:0]            best_mode_o,
    output logic [COST_WIDTH-1:0] best_cost_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [5:0] LAST_MODE = 6'(MODE_NUM - 1);

    logic [1:0]            state_reg;
    logic                  first_reg;
    logic [5:0]            run_mode_reg;
    logic [COST_WIDTH-1:0] run_cost_reg;

    logic [COST_WIDTH-1:0] cost_next;
    logic                  take_next;
    logic [5:0]            win_mode_next;
    logic [COST_WIDTH-1:0] win_cost_next;

    assign busy_o = (state_reg != ST_IDLE);

    // Cost of the current candidate and the running best once it is included.
    // A strict compare over an ascending sweep keeps the lower mode on a tie.
    always_comb begin
        cost_next     = COST_WIDTH'(sad_i) + COST_WIDTH'(bitrate_i);
        take_next     = first_reg || (cost_next < run_cost_reg);
        win_mode_next = take_next ? mode_o    : run_mode_reg;
        win_cost_next = take_next ? cost_next : run_cost_reg;
    end

    // Sweep sequencer: IDLE -> SWEEP (one step per valid SAD) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            first_reg    <= 1'b1;
            run_mode_reg <= '0;
            run_cost_reg <= '1;
            mode_o       <= '0;
            size_o       <= '0;
            position_o   <= '0;
            cost_done_o  <= 1'b0;
            best_mode_o  <= '0;
            best_cost_o  <= '1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cost_done_o <= 1'b0;
                    if (start_i) begin
                        size_o     <= size_i;
                        position_o <= position_i;
                        mode_o     <= '0;
                        first_reg  <= 1'b1;
                        state_reg  <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (sad_valid_i) begin
                        run_mode_reg <= win_mode_next;
                        run_cost_reg <= win_cost_next;
                        first_reg    <= 1'b0;
                        if (mode_o == LAST_MODE) begin
                            // Present the winner so the rate estimator latches it.
                            mode_o      <= win_mode_next;
                            best_mode_o <= win_mode_next;
                            best_cost_o <= win_cost_next;
                            cost_done_o <= 1'b1;
                            state_reg   <= ST_DONE;
                        end else begin
                            mode_o <= mode_o + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    cost_done_o <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    cost_done_o <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_posi_mode_decision.sv
// Testbench for posi_mode_decision: table-driven SAD/rate sources indexed by
// mode_o, a plain min-search reference, and one line per PU transaction.
module tb_posi_mode_decision;

    localparam int SW     = 20;
    localparam int MN     = 35;
    localparam int CW     = SW + 1;
    localparam int LAMBDA = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [1:0]    size_i;
    logic [7:0]    position_i;
    logic          sad_valid_i;
    logic [SW-1:0] sad_i;
    logic [12:0]   bitrate_i;
    logic          busy_o;
    logic [5:0]    mode_o;
    logic [1:0]    size_o;
    logic [7:0]    position_o;
    logic          cost_done_o;
    logic [5:0]    best_mode_o;
    logic [CW-1:0] best_cost_o;

    int sad_tbl  [64];
    int rate_tbl [64];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    posi_mode_decision #(.SAD_WIDTH(SW), .MODE_NUM(MN), .COST_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .size_i      (size_i),
        .position_i  (position_i),
        .sad_valid_i (sad_valid_i),
        .sad_i       (sad_i),
        .bitrate_i   (bitrate_i),
        .busy_o      (busy_o),
        .mode_o      (mode_o),
        .size_o      (size_o),
        .position_o  (position_o),
        .cost_done_o (cost_done_o),
        .best_mode_o (best_mode_o),
        .best_cost_o (best_cost_o)
    );

    // Distortion path and rate estimator answer combinationally for mode_o.
    always_comb begin
        sad_i     = SW'(sad_tbl[mode_o]);
        bitrate_i = 13'(rate_tbl[mode_o]);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: cheapest mode over the whole table, first (lowest) mode on ties.
    task automatic ref_best(output int bm, output longint bc);
        bm = 0;
        bc = longint'(sad_tbl[0]) + longint'(rate_tbl[0]);
        for (int m = 1; m < MN; m++) begin
            if (longint'(sad_tbl[m]) + longint'(rate_tbl[m]) < bc) begin
                bm = m;
                bc = longint'(sad_tbl[m]) + longint'(rate_tbl[m]);
            end
        end
    endtask

    // One PU, entered and left at a negedge. gap: 0 none, 1 every 3rd, 2 random.
    task automatic run_pu(input string name, input logic [1:0] sz, input logic [7:0] pos,
                          input int gap, input bit poke);
        int     cyc, nvalid, exp_mode;
        longint exp_cost;
        bit     done, v;
        ref_best(exp_mode, exp_cost);
        start_i = 1'b1; size_i = sz; position_i = pos; sad_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; size_i = ~sz; position_i = ~pos;
        cyc = 1; nvalid = 0; done = 1'b0;
        check({name, "_busy"}, busy_o, 1);
        while (!done && cyc < 1000) begin
            if (cost_done_o) begin
                done = 1'b1;
            end else begin
                check({name, "_mode_step"}, mode_o, nvalid);
                if (gap == 0)      v = 1'b1;
                else if (gap == 1) v = (cyc % 3 == 0);
                else               v = ($urandom_range(0, 2) != 0);
                sad_valid_i = v;
                if (v) nvalid++;
                start_i = poke && (cyc == 4);
                @(negedge clk);
                cyc++;
            end
        end
        check({name, "_timeout"}, done, 1);
        sad_valid_i = 1'b0;
        start_i = poke;  // start in the DONE cycle must be ignored
        if (gap == 0) check({name, "_latency"}, cyc, MN + 1);
        check({name, "_best_mode"}, best_mode_o, exp_mode);
        check({name, "_best_cost"}, best_cost_o, exp_cost);
        check({name, "_mode_at_done"}, mode_o, exp_mode);
        check({name, "_size"}, size_o, sz);
        check({name, "_pos"}, position_o, pos);
        @(negedge clk);
        start_i = 1'b0;
        check({name, "_pulse_end"}, cost_done_o, 0);
        check({name, "_idle"}, busy_o, 0);
        check({name, "_mode_hold"}, mode_o, exp_mode);
        $display("PU %s: size=%0d pos=%0h gap=%0d best_mode=%0d best_cost=%0d exp_mode=%0d exp_cost=%0d cycles=%0d",
                 name, sz, pos, gap, best_mode_o, best_cost_o, exp_mode, exp_cost, cyc);
    endtask

    initial begin
        int nb, guard;
        bit seen;
        rst = 1'b1; start_i = 1'b0; size_i = '0; position_i = '0; sad_valid_i = 1'b0;
        for (int m = 0; m < 64; m++) begin sad_tbl[m] = 0; rate_tbl[m] = 0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_mode", mode_o, 0);
        check("rst_best_cost", best_cost_o, (longint'(1) << CW) - 1);
        check("rst_done", cost_done_o, 0);

        // Reset mid-sweep at mode 12.
        start_i = 1'b1; size_i = 2'd2; position_i = 8'h10;
        @(negedge clk);
        start_i = 1'b0; sad_valid_i = 1'b1;
        guard = 0;
        while (mode_o != 6'd12 && guard < 100) begin @(negedge clk); guard++; end
        check("mid_mode12", mode_o, 12);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_mode", mode_o, 0);
        check("abort_best_cost", best_cost_o, (longint'(1) << CW) - 1);
        check("abort_size", size_o, 0);
        seen = 1'b0;
        repeat (50) begin @(negedge clk); if (cost_done_o || busy_o) seen = 1'b1; end
        check("abort_no_pulse", seen, 0);
        sad_valid_i = 1'b0;
        $display("PU abort: reset at mode 12, idle afterwards busy=%0d", busy_o);

        // Basic sweep.
        for (int m = 0; m < 64; m++) begin sad_tbl[m] = 1000; rate_tbl[m] = 40; end
        sad_tbl[26] = 200;
        run_pu("basic", 2'd1, 8'h00, 0, 1'b0);
        check("basic_cost240", best_cost_o, 240);

        // Rate-driven tie-break.
        for (int m = 0; m < 64; m++) begin sad_tbl[m] = 500; rate_tbl[m] = 40; end
        rate_tbl[10] = 15; rate_tbl[20] = 15;
        run_pu("tie", 2'd2, 8'h08, 0, 1'b0);
        check("tie_mode10", best_mode_o, 10);

        // Gapped valid with start pokes, same tables as basic.
        for (int m = 0; m < 64; m++) begin sad_tbl[m] = 1000; rate_tbl[m] = 40; end
        sad_tbl[26] = 200;
        run_pu("gapped", 2'd3, 8'h20, 1, 1'b1);

        // Width extremes.
        for (int m = 0; m < 64; m++) begin sad_tbl[m] = (1 << SW) - 1; rate_tbl[m] = 8191; end
        run_pu("extreme", 2'd0, 8'hff, 0, 1'b0);
        check("extreme_cost", best_cost_o, 1056766);

        // Back-to-back with a neighbour-aware rate model.
        for (int m = 0; m < 64; m++) begin
            sad_tbl[m] = 3000 + int'($urandom_range(0, 500)); rate_tbl[m] = 8 * LAMBDA;
        end
        sad_tbl[5] = 100;
        run_pu("nb_pu0", 2'd1, 8'h00, 0, 1'b0);
        nb = 5;
        for (int m = 0; m < 64; m++) begin
            sad_tbl[m] = 1000; rate_tbl[m] = (m == nb) ? 3 * LAMBDA : 8 * LAMBDA;
        end
        run_pu("nb_pu1", 2'd1, 8'h04, 0, 1'b0);
        check("nb_cost", best_cost_o, 1000 + 3 * LAMBDA);

        // Randomized PUs with narrow ranges so ties happen often.
        for (int t = 0; t < 6; t++) begin
            for (int m = 0; m < 64; m++) begin
                if (t < 3) begin
                    sad_tbl[m] = int'($urandom_range(0, 40));
                    rate_tbl[m] = int'($urandom_range(0, 20));
                end else begin
                    sad_tbl[m] = int'($urandom_range(0, (1 << SW) - 1));
                    rate_tbl[m] = int'($urandom_range(0, 8191));
                end
            end
            run_pu($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/posi_mode_decision.md
Name: posi_mode_decision

Overview:
- Intra-mode sweep sequencer and RD-cost comparator for one PU.
- Drives candidate modes to the rate estimator and receives the rate estimator's combinational bitrate in the same cycle.
- Adds SAD from the distortion path to that bitrate, tracks the minimum-cost mode, and issues the cost_done pulse with the winning mode. The rate estimator uses that pulse to update its top/left neighbour-mode buffers.

Parameters:
- SAD_WIDTH, 20, width of the distortion input.
- MODE_NUM, 35, number of candidate modes swept, 0..MODE_NUM-1 (legal 2..63).
- COST_WIDTH, SAD_WIDTH+1, width of the cost output; must be at least max(SAD_WIDTH,13)+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin sweep for one PU; honoured only in IDLE
- size_i  in  2  PU size (SIZE_04/08/16/32), latched on accepted start
- position_i  in  8  PU z-order position in LCU, latched on accepted start
- sad_valid_i  in  1  sad_i valid for current mode_o
- sad_i  in  SAD_WIDTH  distortion of current mode_o
- bitrate_i  in  13  lambda-weighted rate for current mode_o/size_o/position_o
- busy_o  out  1  high in SWEEP and DONE
- mode_o  out  6  candidate mode to rate estimator; best mode during DONE
- size_o  out  2  latched size
- position_o  out  8  latched position
- cost_done_o  out  1  one-cycle pulse; result valid
- best_mode_o  out  6  winning mode
- best_cost_o  out  COST_WIDTH  winning cost sad+bitrate

Behaviour:
- Reset (rst high at posedge; synchronous; overrides everything):
  - State IDLE.
  - busy_o=0, cost_done_o=0, mode_o=0, size_o=0, position_o=0, best_mode_o=0, best_cost_o=all-ones.
  - Reset during SWEEP/DONE aborts: no cost_done_o pulse, results discarded.
- IDLE:
  - start_i=1 -> latch size_i/position_i into size_o/position_o, set mode_o=0, set first flag, go SWEEP next cycle.
  - sad_valid_i in IDLE is ignored.
- SWEEP:
  - busy_o=1. mode_o holds until sad_valid_i=1.
  - On sad_valid_i: cost = zero-extended sad_i + zero-extended bitrate_i, computed at COST_WIDTH with no overflow.
  - If first flag set, or cost < running best (strict): running best := {mode_o, cost}. Clear first flag.
  - Tie-break: on equal cost the lower mode wins.
  - If mode_o == MODE_NUM-1: go DONE. Otherwise mode_o += 1.
  - start_i is ignored while busy.
- DONE (exactly one cycle):
  - cost_done_o=1, mode_o=running best mode, best_mode_o/best_cost_o loaded with the running best, size_o/position_o unchanged. The rate estimator therefore stores the winner.
  - Next cycle: IDLE, cost_done_o=0.
  - best_mode_o/best_cost_o and mode_o hold until the next accepted start.
- Latency:
  - start -> first mode_o=0 visible: 1 cycle.
  - Last sad_valid_i -> cost_done_o: 1 cycle.
  - Minimum PU time with sad_valid_i held high: MODE_NUM+2 cycles including the IDLE start cycle.
- start_i asserted in the DONE cycle is ignored. Back-to-back PUs need start_i in IDLE, earliest the cycle after DONE.
- No internal timeout: SWEEP waits indefinitely for sad_valid_i.

Test Plan:
- Reset values:
  - Assert rst 3 cycles mid-SWEEP (mode_o=12) -> IDLE, busy_o=0, mode_o=0, best_cost_o=all-ones, no cost_done_o pulse thereafter.
- Basic sweep, MODE_NUM=35:
  - start with size=SIZE_08, pos=0x00; sad_valid_i held high.
  - sad_i=1000 except mode 26 sad=200; bitrate_i=40 constant.
  - -> cost_done_o pulses once, 36 cycles after the start cycle; best_mode_o=26, best_cost_o=240; mode_o=26 during pulse.
- Rate-driven tie-break:
  - all sad_i=500; bitrate_i=15 for modes 10 and 20, 40 otherwise.
  - -> best_mode_o=10, best_cost_o=515.
- Gapped sad_valid_i:
  - valid every 3rd cycle -> mode_o steps only on valid cycles; result identical to the gapless run.
  - start_i pulsed during SWEEP -> no restart, size_o unchanged.
- Width extremes:
  - sad_i=2^20-1, bitrate_i=8191 all modes -> best_cost_o=1056766, best_mode_o=0, no wrap.
- Back-to-back with rate estimator attached:
  - PU at pos 0x00 wins mode 5; start PU at pos 0x04 (right neighbour) the cycle after DONE.
  - -> bitrate_i for mode 5 equals lambda*3; stored neighbour mode confirmed 5.
